// File: rtl/md_unit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_ctrl_pkg
// Purpose  : Shared operation codes and widths for the multiply/divide unit.
//            The op encoding matches the MD_* codes used by the decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package md_unit_ctrl_pkg;

  localparam int MD_W = 32;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_ctrl_compute.sv
`default_nettype none
// ============================================================================
// Module   : md_compute
// Purpose  : Purely combinational multiply/divide datapath. Produces the HI/LO
//            result for the latched op/operands; the sequencing lives in the
//            parent controller.
// Ports    : op     in  4   latched op code
//            a, b   in  32  latched rs / rt operands
//            hi_res out 32  HI result (product high word or remainder)
//            lo_res out 32  LO result (product low word or quotient)
//            div0   out 1   divide op with zero divisor; write-back suppressed
// Revision : 1.0 - initial release
// ============================================================================
module md_compute
  import md_unit_ctrl_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [MD_W-1:0] a,
  input  logic [MD_W-1:0] b,
  output logic [MD_W-1:0] hi_res,
  output logic [MD_W-1:0] lo_res,
  output logic            div0
);

  logic [2*MD_W-1:0] prod_s;
  logic [2*MD_W-1:0] prod_u;
  logic [MD_W-1:0]   divisor;
  logic [MD_W-1:0]   quot_s;
  logic [MD_W-1:0]   rem_s;
  logic [MD_W-1:0]   quot_u;
  logic [MD_W-1:0]   rem_u;

  assign prod_s = $unsigned($signed({{MD_W{a[MD_W-1]}}, a}) * $signed({{MD_W{b[MD_W-1]}}, b}));
  assign prod_u = {{MD_W{1'b0}}, a} * {{MD_W{1'b0}}, b};

  assign div0    = ((op == MD_DIV) || (op == MD_DIVU)) && (b == '0);
  // Substitute a harmless divisor so the dividers never see zero.
  assign divisor = (b == '0) ? {{(MD_W-1){1'b0}}, 1'b1} : b;

  // SystemVerilog signed / and % truncate toward zero, remainder follows dividend.
  assign quot_s = $unsigned($signed(a) / $signed(divisor));
  assign rem_s  = $unsigned($signed(a) % $signed(divisor));
  assign quot_u = a / divisor;
  assign rem_u  = a % divisor;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op)
      MD_MULT:  {hi_res, lo_res} = prod_s;
      MD_MULTU: {hi_res, lo_res} = prod_u;
      MD_DIV:   begin hi_res = rem_s; lo_res = quot_s; end
      MD_DIVU:  begin hi_res = rem_u; lo_res = quot_u; end
      default:  ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_ctrl
// Purpose  : Multi-cycle multiply/divide unit. Owns HI/LO, latches operands on
//            start, counts down the operation latency and writes the result
//            when the count expires. Raises md_stall for HI/LO users in D.
// Ports    : clk       in  1   rising-edge clock
//            reset     in  1   synchronous active-high reset
//            md_op_E   in  4   op of the instruction in E
//            rs_E      in  32  forwarded rs in E
//            rt_E      in  32  forwarded rt in E
//            md_use_D  in  1   D-stage instruction touches HI/LO
//            start     out 1   long op accepted this cycle (combinational)
//            busy      out 1   operation in flight (registered)
//            md_stall  out 1   hold D-stage HI/LO user (combinational)
//            hi, lo    out 32  HI / LO registers
// Revision : 1.0 - initial release
// ============================================================================
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      md_op_E,
  input  logic [MD_W-1:0] rs_E,
  input  logic [MD_W-1:0] rt_E,
  input  logic            md_use_D,
  output logic            start,
  output logic            busy,
  output logic            md_stall,
  output logic [MD_W-1:0] hi,
  output logic [MD_W-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [MD_W-1:0]  a_q;
  logic [MD_W-1:0]  b_q;
  logic [MD_W-1:0]  hi_q;
  logic [MD_W-1:0]  lo_q;

  logic [MD_W-1:0]  hi_res;
  logic [MD_W-1:0]  lo_res;
  logic             div0;
  logic             is_mult_d;

  md_compute u_compute (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  assign start     = is_long_op(md_op_E) && !busy_q;
  assign md_stall  = md_use_D && (start || busy_q);
  assign is_mult_d = (md_op_E == MD_MULT) || (md_op_E == MD_MULTU);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (busy_q) begin
      // Any op arriving while busy is dropped; only the countdown advances.
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
        if (!div0) begin
          hi_q <= hi_res;
          lo_q <= lo_res;
        end
      end
    end else if (start) begin
      busy_q <= 1'b1;
      op_q   <= md_op_E;
      a_q    <= rs_E;
      b_q    <= rt_E;
      cnt_q  <= is_mult_d ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (md_op_E == MD_MTHI) begin
      hi_q <= rs_E;
    end else if (md_op_E == MD_MTLO) begin
      lo_q <= rs_E;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit_ctrl
// Purpose  : Directed self-checking bench for md_unit_ctrl with hand-computed
//            HI/LO results, busy latency and stall behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op_E;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        md_use_D;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op_E  (md_op_E),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .md_use_D (md_use_D),
    .start    (start),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a long op, scramble the E operands after the start edge, and
  // count busy cycles (bounded).
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n);
    int cnt;
    md_op_E = op; rs_E = a; rt_E = b;
    #1;
    chk({tag, "_start"}, 32'(start), 32'd1);
    step();
    md_op_E = MD_NONE; rs_E = 32'hDEAD_BEEF; rt_E = 32'h0;
    #1;
    chk({tag, "_stall"}, 32'(md_stall), 32'(md_use_D));
    cnt = 0;
    while (busy === 1'b1 && cnt < 30) begin
      cnt++;
      step();
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
  endtask

  initial begin
    reset = 1'b1; md_op_E = MD_NONE; rs_E = '0; rt_E = '0; md_use_D = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_hi",    hi, 32'h0);
    chk("rst_lo",    lo, 32'h0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_stall", 32'(md_stall), 32'd0);

    // mult 3 * -2 with an mflo waiting in D
    md_use_D = 1'b1;
    md_op_E = MD_MULT; rs_E = 32'd3; rt_E = 32'hFFFF_FFFE;
    #1;
    chk("mult_start_c0", 32'(start), 32'd1);
    chk("mult_stall_c0", 32'(md_stall), 32'd1);
    step();                                   // c1
    md_op_E = MD_NONE; rs_E = 32'h0; rt_E = 32'h0;
    #1;
    chk("mult_busy_c1",  32'(busy), 32'd1);
    chk("mult_stall_c1", 32'(md_stall), 32'd1);
    step();                                   // c2: new mult while busy
    md_op_E = MD_MULT; rs_E = 32'd5; rt_E = 32'd5;
    #1;
    chk("mult_nostart_busy", 32'(start), 32'd0);
    chk("mult_busy_c2",      32'(busy), 32'd1);
    step();                                   // c3: mtlo while busy
    md_op_E = MD_MTLO; rs_E = 32'h1234;
    #1;
    chk("mult_busy_c3",  32'(busy), 32'd1);
    step();                                   // c4
    md_op_E = MD_NONE; rs_E = 32'h0;
    #1;
    chk("mult_busy_c4",  32'(busy), 32'd1);
    chk("mult_stall_c4", 32'(md_stall), 32'd1);
    step();                                   // c5
    chk("mult_busy_c5",  32'(busy), 32'd1);
    chk("mult_stall_c5", 32'(md_stall), 32'd1);
    step();                                   // c6
    chk("mult_busy_c6",  32'(busy), 32'd0);
    chk("mult_stall_c6", 32'(md_stall), 32'd0);
    chk("mult_hi",       hi, 32'hFFFF_FFFF);
    chk("mult_lo",       lo, 32'hFFFF_FFFA);
    md_use_D = 1'b0;

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op("divu", MD_DIVU, 32'd7, 32'd2, 10);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    // mthi / mtlo, zero latency
    md_op_E = MD_MTHI; rs_E = 32'h11;
    #1;
    chk("mthi_nostart", 32'(start), 32'd0);
    step();
    md_op_E = MD_MTLO; rs_E = 32'h22;
    chk("mthi_hi", hi, 32'h11);
    step();
    md_op_E = MD_NONE;
    chk("mtlo_lo",   lo, 32'h22);
    chk("mtlo_busy", 32'(busy), 32'd0);

    run_op("div0", MD_DIV, 32'd5, 32'd0, 10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    md_op_E = MD_MTHI; rs_E = 32'hABCD;
    step();
    md_op_E = MD_NONE;
    chk("mthi2_hi", hi, 32'hABCD);

    // reset during busy cycle 3 of div 100,7
    md_op_E = MD_DIV; rs_E = 32'd100; rt_E = 32'd7;
    step();                                   // busy cycle 1
    md_op_E = MD_NONE;
    step();                                   // busy cycle 2
    step();                                   // busy cycle 3
    chk("rstmid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_hi",   hi, 32'h0);
    chk("rstmid_lo",   lo, 32'h0);
    for (int i = 0; i < 12; i++) step();
    chk("rstmid_late_busy", 32'(busy), 32'd0);
    chk("rstmid_late_hi",   hi, 32'h0);
    chk("rstmid_late_lo",   lo, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
